// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the sequential multi-word adder/subtractor:
// FSM states, word width and a constant-evaluable clog2.
package multiword_add_seq_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multiword_add_seq_cla16.sv
// 16-bit carry-look-ahead adder: four 4-bit lookahead groups joined by a
// second-level lookahead unit over the group generate/propagate terms.
module CLA_16
  import multiword_add_seq_pkg::*;
(
  input  logic [WORD_W-1:0] in1,
  input  logic [WORD_W-1:0] in2,
  input  logic              Cin,
  output logic [WORD_W-1:0] Sum,
  output logic              Cout
);

  // Returns {c4, c3, c2, c1, c0} for one 4-wide lookahead block.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic ci);
    logic [4:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;
  logic [15:0] c;

  assign g = in1 & in2;
  assign p = in1 ^ in2;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      grp_g[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      grp_p[i] = &p[4*i +: 4];
    end
  end

  assign grp_c = cla4(grp_g, grp_p, Cin);

  always_comb begin
    logic [4:0] cc;
    c = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cc = cla4(g[4*i +: 4], p[4*i +: 4], grp_c[i]);
      c[4*i +: 4] = cc[3:0];
    end
  end

  assign Sum  = p ^ c;
  assign Cout = grp_c[4];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential WORDS x 16-bit adder/subtractor: streams operands through one
// CLA_16 least-significant word first, rippling the carry through a register.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W*WORDS-1:0]   op_a,
  input  logic [WORD_W*WORDS-1:0]   op_b,
  input  logic                      cin,
  input  logic                      sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W*WORDS-1:0]   result,
  output logic                      cout,
  output logic                      ovf,
  output logic                      zero
);

  localparam int unsigned W     = WORD_W * WORDS;
  localparam int unsigned IDX_W = (clog2(WORDS) < 1) ? 1 : clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              carry_q, carry_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W-1:0]      result_q, result_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic [WORD_W-1:0] sum_word;
  logic              cout_word;
  logic [W-1:0]      merged;

  assign a_word = a_q[int'(idx_q)*WORD_W +: WORD_W];
  assign b_word = b_q[int'(idx_q)*WORD_W +: WORD_W];

  CLA_16 u_cla (
    .in1  (a_word),
    .in2  (b_word),
    .Cin  (carry_q),
    .Sum  (sum_word),
    .Cout (cout_word)
  );

  // Result as it will be after this edge, so zero covers the final word too.
  always_comb begin
    merged = result_q;
    merged[int'(idx_q)*WORD_W +: WORD_W] = sum_word;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d = merged;
        carry_d  = cout_word;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = cout_word;
          ovf_d   = (a_word[WORD_W-1] == b_word[WORD_W-1]) &&
                    (sum_word[WORD_W-1] != a_word[WORD_W-1]);
          zero_d  = (merged == '0);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
